// File: rtl/inst_mem_loader.sv
// Synchronous-read instruction memory with a valid/ready program-load port and fetch-fault reporting.
// Define INST_MEM_PARITY_EN to store a per-word even-parity bit and report FaultCode 11 on mismatch.
module inst_mem_loader #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LoadStart,
  input  logic              LoadValid,
  input  logic [31:0]       LoadData,
  input  logic              LoadLast,
  output logic              LoadReady,
  output logic [ADDR_W:0]   LoadCount,
  output logic              Loading,
  input  logic              FetchReq,
  input  logic [31:0]       Addr,
  output logic              FetchReady,
  output logic              InstValid,
  output logic [31:0]       Inst,
  output logic              Fault,
  output logic [1:0]        FaultCode
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned HI_LSB  = ADDR_W + 2;
`ifdef INST_MEM_PARITY_EN
  localparam int unsigned MEM_W   = 33;
`else
  localparam int unsigned MEM_W   = 32;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [MEM_W-1:0]   mem [DEPTH];

  logic               load_accept_c;
  logic               fetch_accept_c;
  logic [ADDR_W-1:0]  ptr_c;
  logic [ADDR_W-1:0]  idx_c;
  logic [MEM_W-1:0]   rd_word_c;
  logic [MEM_W-1:0]   wr_word_c;
  logic               misaligned_c;
  logic               out_range_c;
  logic               parity_err_c;

  // The load pointer is the low bits of the word count; it never reaches DEPTH while in LOAD.
  assign ptr_c        = LoadCount[ADDR_W-1:0];
  assign idx_c        = Addr[ADDR_W+1:2];
  assign rd_word_c    = mem[idx_c];
  assign misaligned_c = (Addr[1:0] != 2'b00);
  assign out_range_c  = ((Addr >> HI_LSB) != 32'd0);

`ifdef INST_MEM_PARITY_EN
  assign wr_word_c    = {^LoadData, LoadData};
  assign parity_err_c = ^rd_word_c;
`else
  assign wr_word_c    = LoadData;
  assign parity_err_c = 1'b0;
`endif

  // Next-state and handshake acceptance; LoadStart in LOAD drops a coincident beat.
  always_comb begin
    state_d        = state_q;
    load_accept_c  = 1'b0;
    fetch_accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (LoadStart) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_accept_c = LoadValid && LoadReady && !LoadStart;
        if (load_accept_c && (LoadLast || (ptr_c == ADDR_W'(DEPTH - 1)))) state_d = S_RUN;
      end
      S_RUN: begin
        fetch_accept_c = FetchReq && FetchReady;
        if (LoadStart) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, load counter and fetch result registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      LoadReady  <= 1'b0;
      Loading    <= 1'b0;
      FetchReady <= 1'b0;
      LoadCount  <= '0;
      InstValid  <= 1'b0;
      Inst       <= '0;
      Fault      <= 1'b0;
      FaultCode  <= 2'b00;
    end else begin
      state_q    <= state_d;
      LoadReady  <= (state_d == S_LOAD);
      Loading    <= (state_d == S_LOAD);
      FetchReady <= (state_d == S_RUN);

      if (LoadStart) begin
        LoadCount <= '0;
      end else if (load_accept_c) begin
        LoadCount <= LoadCount + CNT_W'(1);
      end

      InstValid <= fetch_accept_c;
      if (fetch_accept_c) begin
        if (misaligned_c) begin
          Inst      <= NOP_WORD;
          Fault     <= 1'b1;
          FaultCode <= 2'b01;
        end else if (out_range_c) begin
          Inst      <= NOP_WORD;
          Fault     <= 1'b1;
          FaultCode <= 2'b10;
        end else if (parity_err_c) begin
          Inst      <= NOP_WORD;
          Fault     <= 1'b1;
          FaultCode <= 2'b11;
        end else begin
          Inst      <= rd_word_c[31:0];
          Fault     <= 1'b0;
          FaultCode <= 2'b00;
        end
      end else begin
        Fault     <= 1'b0;
        FaultCode <= 2'b00;
      end
    end
  end

  // Storage array is deliberately left out of reset so a reload can keep earlier words.
  always_ff @(posedge Clk) begin
    if (load_accept_c && !Reset) begin
      mem[ptr_c] <= wr_word_c;
    end
  end

endmodule
